// File: rtl/lcd_nibble_receiver.sv
// lcd_nibble_receiver: watches the 4-bit LCD write bus (E/RS/D[3:0]), pairs
// nibbles into bytes, tracks the DDRAM address the panel would be pointing
// at, and flags E-width, nibble-gap, byte-gap and RS-consistency violations.
module lcd_nibble_receiver #(
  parameter int E_MIN_HIGH = 12,
  parameter int NIBBLE_GAP = 50,
  parameter int BYTE_GAP   = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic [3:0] lcd_data,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       byte_rs,
  output logic [6:0] ddram_addr,
  output logic       timing_err,
  output logic [2:0] err_code
);

  localparam logic WAIT_UPPER = 1'b0;
  localparam logic WAIT_LOWER = 1'b1;

  localparam logic [11:0] CNT_MAX = 12'hFFF;

  localparam logic [2:0] ERR_NONE = 3'b000;
  localparam logic [2:0] ERR_E    = 3'b001;
  localparam logic [2:0] ERR_NIB  = 3'b010;
  localparam logic [2:0] ERR_BYTE = 3'b011;
  localparam logic [2:0] ERR_RS   = 3'b100;

  // Thresholds widened to 13 bits so gap_cnt+1 never overflows the compare.
  localparam logic [12:0] E_MIN    = 13'(E_MIN_HIGH);
  localparam logic [12:0] NIB_MIN  = 13'(NIBBLE_GAP);
  localparam logic [12:0] BYTE_MIN = 13'(BYTE_GAP);

  logic        e_q;
  logic        state;
  logic [3:0]  upper_q;
  logic        rs_q;
  logic        first_seen;
  logic [11:0] hi_cnt;
  logic [11:0] gap_cnt;

  logic        fall;
  logic [12:0] gap_next;
  logic        e_viol, nib_viol, byte_viol, rs_viol;
  logic [2:0]  err_next;
  logic [6:0]  addr_next;

  assign fall     = e_q & ~lcd_e;
  // gap_cnt restarts at 0 the cycle after an edge, so +1 is the true spacing.
  assign gap_next = {1'b0, gap_cnt} + 13'd1;

  // Violation detection on the falling-edge cycle, highest code wins.
  always_comb begin
    e_viol    = fall && ({1'b0, hi_cnt} < E_MIN);
    nib_viol  = fall && (state == WAIT_LOWER) && (gap_next < NIB_MIN);
    byte_viol = fall && (state == WAIT_UPPER) && first_seen && (gap_next < BYTE_MIN);
    rs_viol   = fall && (state == WAIT_LOWER) && (lcd_rs != rs_q);
    err_next  = ERR_NONE;
    if (e_viol)         err_next = ERR_E;
    else if (nib_viol)  err_next = ERR_NIB;
    else if (byte_viol) err_next = ERR_BYTE;
    else if (rs_viol)   err_next = ERR_RS;
  end

  // Address the HD44780 cursor moves to after the byte just delivered.
  always_comb begin
    addr_next = ddram_addr;
    if (byte_rs)
      addr_next = ddram_addr + 7'd1;
    else if (byte_out[7])
      addr_next = byte_out[6:0];
    else if (byte_out == 8'h01 || byte_out == 8'h02)
      addr_next = 7'd0;
  end

  // One-cycle delayed copy of E for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) e_q <= 1'b0;
    else        e_q <= lcd_e;
  end

  // E-high width counter, saturating so a stuck-high E never wraps to short.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              hi_cnt <= '0;
    else if (!lcd_e)         hi_cnt <= '0;
    else if (hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + 12'd1;
  end

  // Edge-to-edge spacing counter, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  gap_cnt <= '0;
    else if (fall)               gap_cnt <= '0;
    else if (gap_cnt != CNT_MAX) gap_cnt <= gap_cnt + 12'd1;
  end

  // Nibble pairing FSM; violating nibbles are still accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= WAIT_UPPER;
      upper_q    <= '0;
      rs_q       <= 1'b0;
      first_seen <= 1'b0;
    end else if (fall) begin
      first_seen <= 1'b1;
      if (state == WAIT_UPPER) begin
        upper_q <= lcd_data;
        rs_q    <= lcd_rs;
        state   <= WAIT_LOWER;
      end else begin
        state   <= WAIT_UPPER;
      end
    end
  end

  // Byte delivery one cycle after the lower-nibble edge; RS from the upper.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_valid <= 1'b0;
      byte_out   <= '0;
      byte_rs    <= 1'b0;
    end else begin
      byte_valid <= fall && (state == WAIT_LOWER);
      if (fall && (state == WAIT_LOWER)) begin
        byte_out <= {upper_q, lcd_data};
        byte_rs  <= rs_q;
      end
    end
  end

  // DDRAM address tracking, applied when the byte is presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          ddram_addr <= '0;
    else if (byte_valid) ddram_addr <= addr_next;
  end

  // Sticky error flag plus code of the most recent violation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timing_err <= 1'b0;
      err_code   <= ERR_NONE;
    end else if (err_next != ERR_NONE) begin
      timing_err <= 1'b1;
      err_code   <= err_next;
    end
  end

endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Bench for lcd_nibble_receiver. BYTE_GAP is scaled down to 200 cycles so the
// long character streams stay short; the other thresholds keep their defaults.
`timescale 1ns/1ps
module tb_lcd_nibble_receiver;

  localparam int E_MIN = 12;
  localparam int NG    = 50;
  localparam int BG    = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lcd_e = 1'b0;
  logic       lcd_rs = 1'b0;
  logic [3:0] lcd_data = 4'h0;
  logic       byte_valid;
  logic [7:0] byte_out;
  logic       byte_rs;
  logic [6:0] ddram_addr;
  logic       timing_err;
  logic [2:0] err_code;

  lcd_nibble_receiver #(.E_MIN_HIGH(E_MIN), .NIBBLE_GAP(NG), .BYTE_GAP(BG)) dut (
    .clk(clk), .reset(reset), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_data(lcd_data),
    .byte_valid(byte_valid), .byte_out(byte_out), .byte_rs(byte_rs),
    .ddram_addr(ddram_addr), .timing_err(timing_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; logic rs; } exp_t;
  typedef struct { logic [7:0] b; logic rs; int lat; } obs_t;

  exp_t       exp_q[$];
  obs_t       obs_q[$];
  int         cyc = 0;
  int         last_fall = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_bytes = 0;
  logic [6:0] model_addr = 7'd0;
  obs_t       mon_o;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every delivered byte with its latency from the last falling edge.
  always @(negedge clk) begin
    if (byte_valid) begin
      mon_o.b   = byte_out;
      mon_o.rs  = byte_rs;
      mon_o.lat = cyc - last_fall;
      obs_q.push_back(mon_o);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] addr_after(logic [6:0] a, logic [7:0] b, logic rs);
    if (rs) return a + 7'd1;
    if (b[7]) return b[6:0];
    if (b == 8'h01 || b == 8'h02) return 7'd0;
    return a;
  endfunction

  // One nibble: E high for hi cycles, then low for lo cycles. Called at a negedge.
  task automatic nib(input logic rs, input logic [3:0] d, input int hi, input int lo);
    lcd_rs = rs; lcd_data = d; lcd_e = 1'b1;
    repeat (hi) @(negedge clk);
    lcd_e = 1'b0;
    last_fall = cyc;
    repeat (lo) @(negedge clk);
  endtask

  // Full byte with scoreboard check; bg is the spacing to the next byte.
  task automatic send_byte(input logic [7:0] b, input logic rs_u, input logic rs_l,
                           input int hi_u, input int hi_l, input int ng, input int bg);
    exp_t e;
    obs_t o;
    exp_q.push_back('{b, rs_u});
    model_addr = addr_after(model_addr, b, rs_u);
    nib(rs_u, b[7:4], hi_u, ng - hi_l);
    nib(rs_l, b[3:0], hi_l, bg - 12);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL byte_count: got %0d byte_valid pulses, want 1 (byte %h)", obs_q.size(), b);
      obs_q.delete();
    end else begin
      o = obs_q.pop_front();
      n_bytes++;
      n_checks++;
      if (o.b !== e.b) begin n_fail++; $display("FAIL byte_out: got %h want %h", o.b, e.b); end
      n_checks++;
      if (o.rs !== e.rs) begin n_fail++; $display("FAIL byte_rs: got %b want %b", o.rs, e.rs); end
      n_checks++;
      if (o.lat != 1) begin n_fail++; $display("FAIL latency: got %0d want 1", o.lat); end
    end
    n_checks++;
    if (ddram_addr !== model_addr) begin
      n_fail++; $display("FAIL ddram_addr: got %h want %h (byte %h)", ddram_addr, model_addr, b);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic rs);
    send_byte(b, rs, rs, 12, 12, NG, BG);
  endtask

  task automatic do_reset();
    @(negedge clk);
    lcd_e = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_addr = 7'd0;
    exp_q.delete(); obs_q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", byte_valid); end
    n_checks++; if (byte_out !== 8'h00) begin n_fail++; $display("FAIL rst_byte: got %h want 00", byte_out); end
    n_checks++; if (byte_rs !== 1'b0) begin n_fail++; $display("FAIL rst_rs: got %b want 0", byte_rs); end
    n_checks++; if (ddram_addr !== 7'd0) begin n_fail++; $display("FAIL rst_addr: got %h want 00", ddram_addr); end
    n_checks++; if (timing_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", timing_err); end
    n_checks++; if (err_code !== 3'b000) begin n_fail++; $display("FAIL rst_code: got %b want 000", err_code); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    send(8'h48, 1'b1);
    n_checks++; if (ddram_addr !== 7'd1) begin n_fail++; $display("FAIL single_addr: got %h want 01", ddram_addr); end
    n_checks++; if (timing_err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", timing_err); end
  endtask

  task automatic test_stream();
    int start;
    do_reset();
    start = n_bytes;
    for (int i = 0; i < 56; i++) send(8'h41 + 8'(i % 26), 1'b1);
    n_checks++; if (n_bytes - start != 56) begin n_fail++; $display("FAIL stream_count: got %0d want 56", n_bytes - start); end
    n_checks++; if (ddram_addr !== 7'd56) begin n_fail++; $display("FAIL stream_addr: got %0d want 56", ddram_addr); end
    n_checks++; if (timing_err !== 1'b0) begin n_fail++; $display("FAIL stream_err: got %b want 0", timing_err); end
  endtask

  task automatic test_e_width();
    send_byte(8'h5E, 1'b1, 1'b1, 5, 12, NG, BG);
    n_checks++; if (timing_err !== 1'b1) begin n_fail++; $display("FAIL ewidth_err: got %b want 1", timing_err); end
    n_checks++; if (err_code !== 3'b001) begin n_fail++; $display("FAIL ewidth_code: got %b want 001", err_code); end
  endtask

  task automatic test_gaps();
    send_byte(8'h3C, 1'b1, 1'b1, 12, 12, 30, 100);
    n_checks++; if (err_code !== 3'b010) begin n_fail++; $display("FAIL nibgap_code: got %b want 010", err_code); end
    send(8'h5A, 1'b1);
    n_checks++; if (err_code !== 3'b011) begin n_fail++; $display("FAIL bytegap_code: got %b want 011", err_code); end
    n_checks++; if (timing_err !== 1'b1) begin n_fail++; $display("FAIL gap_sticky: got %b want 1", timing_err); end
  endtask

  task automatic test_rs_mismatch();
    send_byte(8'h61, 1'b1, 1'b0, 12, 12, NG, BG);
    n_checks++; if (err_code !== 3'b100) begin n_fail++; $display("FAIL rs_code: got %b want 100", err_code); end
  endtask

  task automatic test_priority();
    // Lower nibble: short E, short nibble gap and RS mismatch all at once.
    send_byte(8'h77, 1'b0, 1'b1, 12, 5, 30, BG);
    n_checks++; if (err_code !== 3'b001) begin n_fail++; $display("FAIL prio_code: got %b want 001", err_code); end
  endtask

  task automatic test_ddram();
    do_reset();
    send(8'hC0, 1'b0);
    n_checks++; if (ddram_addr !== 7'h40) begin n_fail++; $display("FAIL cmd_c0: got %h want 40", ddram_addr); end
    send(8'h0C, 1'b0);
    n_checks++; if (ddram_addr !== 7'h40) begin n_fail++; $display("FAIL cmd_0c: got %h want 40", ddram_addr); end
    send(8'h01, 1'b0);
    n_checks++; if (ddram_addr !== 7'h00) begin n_fail++; $display("FAIL cmd_01: got %h want 00", ddram_addr); end
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), 1'b1);
    send(8'h02, 1'b0);
    n_checks++; if (ddram_addr !== 7'h00) begin n_fail++; $display("FAIL cmd_02: got %h want 00", ddram_addr); end
    for (int i = 0; i < 127; i++) send(8'h20 + 8'(i % 90), 1'b1);
    n_checks++; if (ddram_addr !== 7'd127) begin n_fail++; $display("FAIL addr_127: got %0d want 127", ddram_addr); end
    send(8'h7E, 1'b1);
    n_checks++; if (ddram_addr !== 7'd0) begin n_fail++; $display("FAIL addr_wrap: got %0d want 0", ddram_addr); end
    n_checks++; if (timing_err !== 1'b0) begin n_fail++; $display("FAIL ddram_err: got %b want 0", timing_err); end
  endtask

  task automatic test_hold_high();
    do_reset();
    // E held past counter saturation must still read as a wide pulse.
    send_byte(8'h4F, 1'b1, 1'b1, 4101, 12, NG, BG);
    n_checks++; if (timing_err !== 1'b0) begin n_fail++; $display("FAIL hold_err: got %b want 0", timing_err); end
    n_checks++; if (err_code !== 3'b000) begin n_fail++; $display("FAIL hold_code: got %b want 000", err_code); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'h41, 1'b1);
    nib(1'b1, 4'hA, 12, NG - 12);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", byte_valid); end
    n_checks++; if (byte_out !== 8'h00) begin n_fail++; $display("FAIL mid_byte: got %h want 00", byte_out); end
    n_checks++; if (ddram_addr !== 7'd0) begin n_fail++; $display("FAIL mid_addr: got %h want 00", ddram_addr); end
    n_checks++; if (err_code !== 3'b000) begin n_fail++; $display("FAIL mid_code: got %b want 000", err_code); end
    reset = 1'b1;
    model_addr = 7'd0;
    repeat (20) @(negedge clk);
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL mid_spurious: got %0d bytes want 0", obs_q.size()); obs_q.delete(); end
    send(8'h52, 1'b1);
    n_checks++; if (ddram_addr !== 7'd1) begin n_fail++; $display("FAIL mid_after_addr: got %h want 01", ddram_addr); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_e_width();
    test_gaps();
    test_rs_mismatch();
    test_priority();
    test_ddram();
    test_hold_high();
    test_reset_mid();
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_fail++; $display("FAIL leftover: exp %0d obs %0d want 0 0", exp_q.size(), obs_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_receiver.md
LCD_NIBBLE_RECEIVER -- requirements
Module: lcd_nibble_receiver

Interface
REQ-001 Parameter E_MIN_HIGH, default 12, minimum LCD_E high width in clk cycles (240 ns at 50 MHz).
REQ-002 Parameter NIBBLE_GAP, default 50, minimum falling-edge-to-falling-edge spacing, upper to lower nibble (1 us).
REQ-003 Parameter BYTE_GAP, default 2000, minimum falling-edge spacing, lower nibble to next upper nibble (40 us).
REQ-004 clk  input  1  single system clock (50 MHz); all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 lcd_e  input  1  LCD enable strobe from the timing-control FSM.
REQ-007 lcd_rs  input  1  register select: 0 command, 1 character data.
REQ-008 lcd_data  input  4  nibble bus (SF_D[11:8] equivalent).
REQ-009 byte_valid  output  1  one-cycle pulse: byte assembled.
REQ-010 byte_out  output  8  assembled byte, stable until the next byte_valid.
REQ-011 byte_rs  output  1  lcd_rs captured with the upper nibble.
REQ-012 ddram_addr  output  7  tracked display address after the last byte.
REQ-013 timing_err  output  1  sticky: any timing violation since reset.
REQ-014 err_code  output  3  last violation: 001 E width, 010 nibble gap, 011 byte gap, 100 RS mismatch.

Function
REQ-015 Register lcd_e once into e_q; a falling edge is the cycle with e_q=1 and lcd_e=0.
REQ-016 In the falling-edge cycle, capture lcd_data and lcd_rs from the current inputs.
REQ-017 hi_cnt (12 bit, saturating at 4095) counts cycles with lcd_e=1 and clears when lcd_e=0.
REQ-018 gap_cnt (12 bit, saturating at 4095) clears on each falling edge and increments otherwise.
REQ-019 FSM states: WAIT_UPPER (reset state) and WAIT_LOWER.
REQ-020 WAIT_UPPER + falling edge: store upper nibble and RS, go to WAIT_LOWER.
REQ-021 WAIT_LOWER + falling edge: form byte {upper, lower}, pulse byte_valid in the next cycle, go to WAIT_UPPER.
REQ-022 E width check: on every falling edge, hi_cnt < E_MIN_HIGH is a violation, code 001.
REQ-023 Nibble gap check: a WAIT_LOWER edge with gap_cnt+1 < NIBBLE_GAP is a violation, code 010.
REQ-024 Byte gap check: a WAIT_UPPER edge with gap_cnt+1 < BYTE_GAP is a violation, code 011; the first edge after reset is exempt.
REQ-025 RS check: lower-nibble RS differing from upper-nibble RS is a violation, code 100; byte_rs keeps the upper-nibble value.
REQ-026 Priority when several violations hit on one edge: 001 > 010 > 011 > 100; err_code shows only the highest.
REQ-027 A violating nibble is still accepted; the FSM advances as normal.
REQ-028 ddram_addr update in the byte_valid cycle:
- byte_rs=1: address +1, wraps 127 to 0.
- byte_rs=0 and byte_out[7]=1: address = byte_out[6:0].
- byte_rs=0 and byte_out=8'h01 or 8'h02: address = 0.
- other commands: address unchanged.
REQ-029 lcd_e held high indefinitely: no action, hi_cnt saturates, no error until a falling edge.
REQ-030 Output latency: from the lower-nibble falling-edge cycle to byte_valid is exactly 1 cycle.

Reset
REQ-031 Reset low: FSM to WAIT_UPPER immediately, including mid-byte; a stored upper nibble is discarded.
REQ-032 Reset values: byte_valid 0, byte_out 8'h00, byte_rs 0, ddram_addr 0, timing_err 0, err_code 000, e_q 0, counters 0, first-edge exemption re-armed.
REQ-033 After reset is released, the first falling edge is treated as an upper nibble.

Verification
REQ-034 Send RS=1 byte 8'h48: E high 12 cycles per nibble, 50-cycle nibble spacing -> byte_valid once, byte_out 8'h48, byte_rs 1, ddram_addr 1, timing_err 0.
REQ-035 Send 56 characters with 2000-cycle byte spacing -> 56 byte_valid pulses matching the sent sequence, ddram_addr 56, timing_err 0.
REQ-036 E high for only 5 cycles on an upper nibble -> timing_err 1, err_code 001, byte still assembled on its lower nibble.
REQ-037 Lower nibble 30 cycles after upper, next byte 1000 cycles after -> err_code 010, then 011, timing_err stays 1.
REQ-038 Command 8'hC0 (RS=0), then 8'h01 -> ddram_addr 7'h40, then 7'h00; 128 data bytes from address 0 wrap ddram_addr back to 0.
REQ-039 Reset pulsed low between upper and lower nibble -> no byte_valid; the next two nibbles form one correct byte; outputs at reset values meanwhile.
